onehot_capture: RTL and testbench
=================================

// Module: onehot_capture
// PURPOSE
//  Downstream stage of the 2-to-4 decoder. Samples the four one-hot lines
//  w1..w4 on a strobe and re-encodes them to a 2-bit code. Flags illegal
//  patterns (none hot, or more than one hot). Buffers results in a small
//  FIFO that is drained with a valid/ready handshake.
//  Counts illegal samples and records dropped strobes for the consumer.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of two, >=2
//  ERRW   8  width of the saturating illegal-pattern counter
// PORTS
//  clk         in   1                  rising-edge clock, sole clock domain
//  rst         in   1                  asynchronous, active-high reset
//  sample      in   1                  strobe: w1..w4 valid this cycle
//  w1,w2,w3,w4 in   1                  one-hot lines from the decoder
//  sample_rdy  out  1                  FIFO can accept (not full)
//  code        out  2                  encoded value at FIFO head
//  code_err    out  1                  head entry came from an illegal pattern
//  out_valid   out  1                  head entry present
//  out_ready   in   1                  consumer accepts head this cycle
//  err_count   out  ERRW               saturating count of accepted illegal samples
//  overflow    out  1                  sticky: a strobe was dropped while full
//  level       out  $clog2(DEPTH)+1    current entry count
// BEHAVIOUR
//  Reset (async, active-high): FIFO empties; pointers are 0.
//   All outputs go low: sample_rdy=0 while rst, then 1 on the first cycle after release.
//   code=0, code_err=0, out_valid=0, err_count=0, overflow=0, level=0.
//   Mid-operation reset discards all entries immediately. No partial pop.
//  Encode (combinational on inputs):
//   w1 -> 2'b00, w2 -> 2'b01, w3 -> 2'b10, w4 -> 2'b11.
//   Zero or >=2 lines high -> code=2'b00, err=1.
//  Push: sample && sample_rdy at a rising edge writes {err,code} at the tail.
//  Pop: out_valid && out_ready at a rising edge advances the head.
//  Occupancy states:
//   EMPTY   -- push -> PARTIAL
//   PARTIAL -- push only: level+1 (-> FULL at DEPTH)
//           -- pop only: level-1 (-> EMPTY at 0)
//           -- push+pop: level unchanged
//   FULL    -- pop -> PARTIAL
//  Head outputs:
//   code/code_err/out_valid are registered from FIFO state; first-word fall-through.
//   Latency: a sample accepted at edge k gives out_valid=1 in the cycle after edge k.
//   out_valid=0 => code=0 and code_err=0. Code outputs are held stable while
//   out_valid && !out_ready.
//  sample_rdy = (level != DEPTH), derived only from registered state.
//   There is no pass-through: a strobe while FULL is dropped even if a pop
//   happens in the same cycle.
//  Dropped strobe (sample && !sample_rdy): no write; overflow set to 1 and held
//   until reset; err_count unchanged.
//  err_count: +1 per accepted illegal sample; saturates at 2**ERRW-1 (no wrap).
//   It does not change on pop.
//  Pointers wrap modulo DEPTH; level in 0..DEPTH, never exceeds DEPTH.
//  The w lines are ignored when sample=0.
// TESTING
//  1 Reset, then hold out_ready=1 and apply sample with w1..w4 = 1000,0100,0010,0001
//    on consecutive cycles -> code 0,1,2,3 in order, each one cycle later, code_err=0.
//  2 out_ready=0 with 3 strobes, DEPTH=2 -> level=2, sample_rdy=0, third strobe
//    dropped, overflow=1. Raise out_ready -> drain the first two codes only.
//  3 Illegal patterns 0000 and 1100 accepted -> code=0 with code_err=1 for both;
//    err_count=2.
//  4 ERRW=2 with 5 illegal samples -> err_count sticks at 3.
//  5 Hold FULL, out_ready=0, and check code stable over 4 cycles. Pulse out_ready
//    and sample together while FULL -> one pop, strobe dropped, level=1.
//  6 Assert rst asynchronously while level=2 -> outputs clear before the next edge.
//    After release, a new sample gives out_valid after one cycle with no stale data.

Source files
------------

// File: rtl/onehot_capture_if.sv
// onehot_capture_if: sample/handshake bundle between the decoder side, the capture stage and its consumer
//   master: drives sample, w1..w4, out_ready; observes everything else
//   slave : the capture stage; drives sample_rdy, code, code_err, out_valid, err_count, overflow, level
interface onehot_capture_if #(
    parameter int DEPTH = 2,
    parameter int ERRW  = 8
);
    logic                     sample;
    logic                     w1, w2, w3, w4;
    logic                     sample_rdy;
    logic [1:0]               code;
    logic                     code_err;
    logic                     out_valid;
    logic                     out_ready;
    logic [ERRW-1:0]          err_count;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   level;
    modport master (
        output sample, w1, w2, w3, w4, out_ready,
        input  sample_rdy, code, code_err, out_valid, err_count, overflow, level
    );
    modport slave (
        input  sample, w1, w2, w3, w4, out_ready,
        output sample_rdy, code, code_err, out_valid, err_count, overflow, level
    );
endinterface

// File: rtl/onehot_capture.sv
// onehot_capture: samples one-hot w1..w4 on a strobe, re-encodes to 2 bits, flags illegal patterns, buffers in a FWFT FIFO
//   clk, rst (async, active-high)
//   bus.sample/w1..w4 in, bus.sample_rdy out   : producer side
//   bus.code/code_err/out_valid out, out_ready : consumer side (valid/ready)
//   bus.err_count, bus.overflow, bus.level     : status
module onehot_capture #(
    parameter int DEPTH = 2,
    parameter int ERRW  = 8
) (
    input logic              clk,
    input logic              rst,
    onehot_capture_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
    state_t          state, state_n;
    logic [LW-1:0]   level_q, level_n;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      mem [DEPTH];
    logic [3:0]      w;
    logic [1:0]      enc;
    logic            legal, run, push, pop;
    logic [ERRW-1:0] err_q;
    logic            ovf_q;
    assign w     = {bus.w4, bus.w3, bus.w2, bus.w1};
    assign legal = (w != 4'd0) && ((w & (w - 4'd1)) == 4'd0);
    assign enc   = legal ? {w[3] | w[2], w[3] | w[1]} : 2'b00;
    // run holds ready low until the first edge after reset release
    assign bus.sample_rdy = run && (state != FULL);
    assign bus.out_valid  = state != EMPTY;
    assign {bus.code_err, bus.code} = bus.out_valid ? mem[rd_ptr] : 3'b000;
    assign bus.err_count  = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.level      = level_q;
    assign push = bus.sample && bus.sample_rdy;
    assign pop  = bus.out_valid && bus.out_ready;
    always_comb begin
        level_n = level_q + LW'(push) - LW'(pop);
        state_n = state;
        if (push != pop)
            state_n = (level_n == '0) ? EMPTY : (level_n == LW'(DEPTH)) ? FULL : PARTIAL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            level_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            run     <= 1'b0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            level_q <= level_n;
            run     <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !legal && err_q != '1) err_q <= err_q + ERRW'(1);
            if (bus.sample && !bus.sample_rdy) ovf_q <= 1'b1;
        end
    end
    // storage needs no reset: the head is masked by out_valid
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {!legal, enc};
endmodule

// File: tb/tb_onehot_capture.sv
// tb_onehot_capture: directed self-checking bench for onehot_capture
module tb_onehot_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    onehot_capture_if #(.DEPTH(2), .ERRW(8)) if0 ();
    onehot_capture_if #(.DEPTH(2), .ERRW(2)) if1 ();
    onehot_capture #(.DEPTH(2), .ERRW(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
    onehot_capture #(.DEPTH(2), .ERRW(2)) u1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v is {w1,w2,w3,w4}
    task automatic drive0(input logic s, input logic [3:0] v);
        if0.sample = s;
        {if0.w1, if0.w2, if0.w3, if0.w4} = v;
    endtask

    task automatic head0(input string tag, input logic v, input logic [1:0] c, input logic e, input int lvl);
        chk({tag, ".valid"}, 32'(if0.out_valid), 32'(v));
        chk({tag, ".code"}, 32'(if0.code), 32'(c));
        chk({tag, ".err"}, 32'(if0.code_err), 32'(e));
        chk({tag, ".level"}, 32'(if0.level), 32'(lvl));
    endtask

    initial begin
        drive0(1'b0, 4'b0000);
        if0.out_ready = 1'b0;
        if1.sample = 1'b0;
        {if1.w1, if1.w2, if1.w3, if1.w4} = 4'b0000;
        if1.out_ready = 1'b0;
        #12;
        chk("rst.rdy", 32'(if0.sample_rdy), 0);
        head0("rst", 1'b0, 2'd0, 1'b0, 0);
        chk("rst.errcnt", 32'(if0.err_count), 0);
        chk("rst.ovf", 32'(if0.overflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rel.rdy_before_edge", 32'(if0.sample_rdy), 0);
        tick();
        chk("rel.rdy", 32'(if0.sample_rdy), 1);
        // 1: legal codes stream through with out_ready held high
        if0.out_ready = 1'b1;
        drive0(1'b1, 4'b1000); tick(); head0("t1.c0", 1'b1, 2'd0, 1'b0, 1);
        drive0(1'b1, 4'b0100); tick(); head0("t1.c1", 1'b1, 2'd1, 1'b0, 1);
        drive0(1'b1, 4'b0010); tick(); head0("t1.c2", 1'b1, 2'd2, 1'b0, 1);
        drive0(1'b1, 4'b0001); tick(); head0("t1.c3", 1'b1, 2'd3, 1'b0, 1);
        drive0(1'b0, 4'b1111); tick(); head0("t1.empty", 1'b0, 2'd0, 1'b0, 0);
        chk("t1.ovf", 32'(if0.overflow), 0);
        // 2: fill, drop third strobe, drain two
        if0.out_ready = 1'b0;
        drive0(1'b1, 4'b1000); tick(); head0("t2.p1", 1'b1, 2'd0, 1'b0, 1);
        drive0(1'b1, 4'b0100); tick(); head0("t2.p2", 1'b1, 2'd0, 1'b0, 2);
        chk("t2.rdy_full", 32'(if0.sample_rdy), 0);
        drive0(1'b1, 4'b0010); tick(); head0("t2.drop", 1'b1, 2'd0, 1'b0, 2);
        chk("t2.ovf", 32'(if0.overflow), 1);
        chk("t2.errcnt", 32'(if0.err_count), 0);
        drive0(1'b0, 4'b0000);
        if0.out_ready = 1'b1;
        tick(); head0("t2.d1", 1'b1, 2'd1, 1'b0, 1);
        tick(); head0("t2.d2", 1'b0, 2'd0, 1'b0, 0);
        // 3: illegal patterns
        if0.out_ready = 1'b0;
        drive0(1'b1, 4'b0000); tick();
        drive0(1'b1, 4'b1100); tick();
        drive0(1'b0, 4'b0000);
        head0("t3.h0", 1'b1, 2'd0, 1'b1, 2);
        chk("t3.errcnt", 32'(if0.err_count), 2);
        if0.out_ready = 1'b1;
        tick(); head0("t3.h1", 1'b1, 2'd0, 1'b1, 1);
        tick(); head0("t3.empty", 1'b0, 2'd0, 1'b0, 0);
        chk("t3.errcnt_pop", 32'(if0.err_count), 2);
        chk("t3.ovf_sticky", 32'(if0.overflow), 1);
        // 5: hold full and stable, then pop with a simultaneous dropped strobe
        if0.out_ready = 1'b0;
        drive0(1'b1, 4'b0001); tick();
        drive0(1'b1, 4'b0010); tick();
        drive0(1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            head0($sformatf("t5.hold%0d", i), 1'b1, 2'd3, 1'b0, 2);
            tick();
        end
        if0.out_ready = 1'b1;
        drive0(1'b1, 4'b1000); tick();
        drive0(1'b0, 4'b0000);
        if0.out_ready = 1'b0;
        head0("t5.popdrop", 1'b1, 2'd2, 1'b0, 1);
        chk("t5.errcnt", 32'(if0.err_count), 2);
        // 6: asynchronous reset mid-cycle while full
        drive0(1'b1, 4'b0100); tick();
        drive0(1'b0, 4'b0000);
        chk("t6.full", 32'(if0.level), 2);
        #2 rst = 1'b1;
        #1;
        head0("t6.async", 1'b0, 2'd0, 1'b0, 0);
        chk("t6.rdy", 32'(if0.sample_rdy), 0);
        chk("t6.ovf", 32'(if0.overflow), 0);
        chk("t6.errcnt", 32'(if0.err_count), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("t6.rdy_after", 32'(if0.sample_rdy), 1);
        head0("t6.idle", 1'b0, 2'd0, 1'b0, 0);
        drive0(1'b1, 4'b0001); tick();
        drive0(1'b0, 4'b0000);
        head0("t6.new", 1'b1, 2'd3, 1'b0, 1);
        tick();
        head0("t6.new_hold", 1'b1, 2'd3, 1'b0, 1);
        // 4: saturating counter on the ERRW=2 instance
        if1.out_ready = 1'b1;
        chk("t4.start", 32'(if1.err_count), 0);
        for (int i = 1; i <= 5; i++) begin
            if1.sample = 1'b1;
            {if1.w1, if1.w2, if1.w3, if1.w4} = (i % 2 == 1) ? 4'b0000 : 4'b0110;
            tick();
            chk($sformatf("t4.cnt%0d", i), 32'(if1.err_count), (i < 3) ? i : 3);
            chk($sformatf("t4.err%0d", i), 32'(if1.code_err), 1);
        end
        if1.sample = 1'b0;
        tick();
        chk("t4.final", 32'(if1.err_count), 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
